// File: rtl/dmem_io_pkg.sv
// ============================================================================
// dmem_io_pkg : IO map addresses and input-port bit positions for dmem_io_ctrl
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dmem_io_pkg;

    localparam logic [15:0] ADDR_DISPLAY = 16'hfff8;
    localparam logic [15:0] ADDR_LED     = 16'hfffa;
    localparam logic [15:0] ADDR_TIMER   = 16'hfffc;
    localparam logic [15:0] ADDR_INPUT   = 16'hfffe;
    localparam int          STICKY_BIT   = 15;

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// ============================================================================
// io_debounce : two-flop synchroniser followed by a consecutive-cycle debouncer
// Revision    : 1.0
// ============================================================================
`default_nettype none

module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // a single cycle of agreement restarts the stability count
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_io_ctrl.sv
// ============================================================================
// dmem_io_ctrl : registered data memory plus memory-mapped board IO behind a
//                req/ready/rvalid port with one-cycle load latency
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_io_ctrl
    import dmem_io_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 16,
    parameter int MEM_WORDS       = 128,
    parameter int SW_COUNT        = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LED_W           = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [6:0]          io_display,
    output logic [LED_W-1:0]    io_led,
    input  logic [SW_COUNT-1:0] io_sw,
    input  logic                io_pb
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0]   mem [MEM_WORDS];
    logic [ADDR_W-1:0]   word_addr;
    logic                unused_addr_lsb;
    logic [IDX_W-1:0]    mem_idx;
    logic                accept;
    logic                wr_acc;
    logic                rd_acc;
    logic                hit_mem;
    logic                hit_disp;
    logic                hit_led;
    logic                hit_timer;
    logic                hit_input;
    logic [SW_COUNT-1:0] sw_db;
    logic                pb_db;
    logic                pb_prev;
    logic                sticky;
    logic [DATA_W-1:0]   timer;
    logic [DATA_W-1:0]   in_word;
    logic [DATA_W-1:0]   rd_val;

    assign word_addr       = {addr[ADDR_W-1:1], 1'b0};
    assign unused_addr_lsb = addr[0];
    assign mem_idx         = addr[IDX_W:1];

    assign accept = req & ready;
    assign wr_acc = accept & write;
    assign rd_acc = accept & ~write;

    assign hit_mem   = word_addr < ADDR_W'(2 * MEM_WORDS);
    assign hit_disp  = word_addr == ADDR_W'(ADDR_DISPLAY);
    assign hit_led   = word_addr == ADDR_W'(ADDR_LED);
    assign hit_timer = word_addr == ADDR_W'(ADDR_TIMER);
    assign hit_input = word_addr == ADDR_W'(ADDR_INPUT);

    generate
        for (genvar i = 0; i < SW_COUNT; i++) begin : g_sw
            io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
                .clock   (clock),
                .reset_n (reset_n),
                .raw     (io_sw[i]),
                .db      (sw_db[i])
            );
        end
    endgenerate

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb_db (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (io_pb),
        .db      (pb_db)
    );

    always_comb begin
        in_word               = '0;
        in_word[SW_COUNT-1:0] = sw_db;
        in_word[SW_COUNT]     = pb_db;
        in_word[STICKY_BIT]   = sticky;
    end

    always_comb begin
        rd_val = '0;
        if (hit_mem) begin
            rd_val = mem[mem_idx];
        end else if (hit_disp) begin
            rd_val = DATA_W'(io_display);
        end else if (hit_led) begin
            rd_val = DATA_W'(io_led);
        end else if (hit_timer) begin
            rd_val = timer;
        end else if (hit_input) begin
            rd_val = in_word;
        end
    end

    // storage array is deliberately left out of reset
    always_ff @(posedge clock) begin
        if (wr_acc && hit_mem) begin
            mem[mem_idx] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready      <= 1'b1;
            rvalid     <= 1'b0;
            rdata      <= '0;
            io_display <= '0;
            io_led     <= '0;
            timer      <= '0;
            sticky     <= 1'b0;
            pb_prev    <= 1'b0;
        end else begin
            // ready only drops during the rvalid cycle, so a load blocks one slot
            rvalid <= rd_acc;
            ready  <= ~rd_acc;
            if (rd_acc) begin
                rdata <= rd_val;
            end
            if (wr_acc && hit_disp) begin
                io_display <= wdata[6:0];
            end
            if (wr_acc && hit_led) begin
                io_led <= wdata[LED_W-1:0];
            end
            timer   <= (wr_acc && hit_timer) ? wdata : timer + 1'b1;
            // a press on the clearing edge wins over the clear
            sticky  <= (pb_db & ~pb_prev) | (sticky & ~(rd_acc & hit_input));
            pb_prev <= pb_db;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_io_ctrl.sv
// ============================================================================
// tb_dmem_io_ctrl : scoreboard bench for dmem_io_ctrl
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_io_ctrl;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        req     = 1'b0;
    logic        write   = 1'b0;
    logic [15:0] addr    = '0;
    logic [15:0] wdata   = '0;
    logic [1:0]  io_sw   = '0;
    logic        io_pb   = 1'b0;
    logic        ready;
    logic        rvalid;
    logic [15:0] rdata;
    logic [6:0]  io_display;
    logic [7:0]  io_led;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_v;

    always #5 clock = ~clock;

    dmem_io_ctrl #(
        .DATA_W(16), .ADDR_W(16), .MEM_WORDS(128),
        .SW_COUNT(2), .DEBOUNCE_CYCLES(4), .LED_W(8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .io_display (io_display),
        .io_led     (io_led),
        .io_sw      (io_sw),
        .io_pb      (io_pb)
    );

    // Presents one request at a negedge once ready is high; returns 1ns after
    // the accept edge. Loads push their expected data onto the scoreboard.
    task automatic bus_op(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!ready && waited < 4) begin
            @(negedge clock);
            waited++;
        end
        if (!ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout ready=%b required=1", ready);
        end
        req = 1'b1; write = w; addr = a; wdata = d;
        if (!w) sb.push_back(exp_rd);
        @(posedge clock);
        #1;
        req = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        n_cmp++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        n_cmp++; if (io_display !== 7'h0) begin n_fail++; $display("FAIL reset_display got=%h exp=00", io_display); end
        n_cmp++; if (io_led !== 8'h0) begin n_fail++; $display("FAIL reset_led got=%h exp=00", io_led); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_memory();
        bus_op(1'b1, 16'h0010, 16'h1234, 16'h0);
        n_cmp++; if (rvalid !== 1'b0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL store_hs rvalid=%b ready=%b exp rvalid=0 ready=1", rvalid, ready);
        end
        bus_op(1'b1, 16'h0000, 16'h5555, 16'h0);
        bus_op(1'b1, 16'h00fe, 16'hbeef, 16'h0);
        bus_op(1'b1, 16'h0020, 16'h1111, 16'h0);
        bus_op(1'b0, 16'h0010, 16'h0, 16'h1234);
        exp_v = sb.pop_front();
        n_cmp++; if (rvalid !== 1'b1 || ready !== 1'b0) begin
            n_fail++; $display("FAIL load_hs rvalid=%b ready=%b exp rvalid=1 ready=0", rvalid, ready);
        end
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL load_0010 got=%h exp=%h", rdata, exp_v); end
        @(posedge clock); #1;
        n_cmp++; if (rvalid !== 1'b0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL load_after rvalid=%b ready=%b exp rvalid=0 ready=1", rvalid, ready);
        end
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL rdata_hold got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'h0011, 16'h0, 16'h1234);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL load_0011 got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'h00ff, 16'h0, 16'hbeef);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL load_top got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'h0000, 16'h0, 16'h5555);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL load_0000 got=%h exp=%h", rdata, exp_v); end
    endtask

    task automatic test_io_regs();
        bus_op(1'b1, 16'hfff8, 16'h007f, 16'h0);
        n_cmp++; if (io_display !== 7'h7f) begin n_fail++; $display("FAIL display got=%h exp=7f", io_display); end
        bus_op(1'b1, 16'hfffa, 16'h01a5, 16'h0);
        n_cmp++; if (io_led !== 8'ha5) begin n_fail++; $display("FAIL led got=%h exp=a5", io_led); end
        bus_op(1'b1, 16'h0100, 16'hdead, 16'h0);
        bus_op(1'b1, 16'hfffe, 16'hffff, 16'h0);
        bus_op(1'b0, 16'hfff9, 16'h0, 16'h007f);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL display_rd got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'hfffa, 16'h0, 16'h00a5);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL led_rd got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'h0100, 16'h0, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++; if (rvalid !== 1'b1 || rdata !== exp_v) begin
            n_fail++; $display("FAIL unmapped_rd rvalid=%b got=%h exp=%h", rvalid, rdata, exp_v);
        end
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL input_idle got=%h exp=%h", rdata, exp_v); end
    endtask

    task automatic test_timer();
        // counts fffe, ffff, 0000, 0001 across the accept edge and three more
        bus_op(1'b1, 16'hfffc, 16'hfffe, 16'h0);
        repeat (3) @(posedge clock);
        bus_op(1'b0, 16'hfffc, 16'h0, 16'h0001);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL timer_wrap got=%h exp=%h", rdata, exp_v); end
    endtask

    task automatic test_debounce();
        @(negedge clock); io_sw = 2'b01;
        repeat (3) @(negedge clock);
        io_sw = 2'b00;
        repeat (10) @(posedge clock);
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL sw_glitch got=%h exp=%h", rdata, exp_v); end
        // change at a negedge; the debounced value flips on the sixth edge
        @(negedge clock); io_sw = 2'b11;
        repeat (5) @(posedge clock);
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL sw_early got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h0003);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL sw_held got=%h exp=%h", rdata, exp_v); end
        @(negedge clock); io_sw = 2'b00;
        repeat (10) @(posedge clock);
    endtask

    task automatic test_sticky();
        @(negedge clock); io_pb = 1'b1;
        repeat (8) @(negedge clock);
        io_pb = 1'b0;
        repeat (10) @(posedge clock);
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h8000);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL sticky_set got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL sticky_clr got=%h exp=%h", rdata, exp_v); end
        // pb_db rises after the sixth edge, so the rise lands on the seventh
        @(negedge clock); io_pb = 1'b1;
        repeat (6) @(posedge clock);
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h0004);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL sticky_race_rd got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h8004);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL sticky_race_kept got=%h exp=%h", rdata, exp_v); end
        bus_op(1'b0, 16'hfffe, 16'h0, 16'h0004);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL sticky_race_clr got=%h exp=%h", rdata, exp_v); end
        @(negedge clock); io_pb = 1'b0;
        repeat (10) @(posedge clock);
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        req = 1'b1; write = 1'b0; addr = 16'h0010; sb.push_back(16'h1234);
        @(posedge clock); #1;
        exp_v = sb.pop_front();
        n_cmp++; if (rvalid !== 1'b1 || rdata !== exp_v) begin
            n_fail++; $display("FAIL b2b_first rvalid=%b got=%h exp=%h", rvalid, rdata, exp_v);
        end
        // held request during the busy cycle must be ignored, then taken
        @(negedge clock); addr = 16'h0000; sb.push_back(16'h5555);
        @(posedge clock); #1;
        n_cmp++; if (rvalid !== 1'b0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap rvalid=%b ready=%b exp rvalid=0 ready=1", rvalid, ready);
        end
        @(posedge clock); #1;
        exp_v = sb.pop_front();
        n_cmp++; if (rvalid !== 1'b1 || rdata !== exp_v) begin
            n_fail++; $display("FAIL b2b_second rvalid=%b got=%h exp=%h", rvalid, rdata, exp_v);
        end
        // a store offered only while ready is low never lands
        @(negedge clock); write = 1'b1; addr = 16'h0020; wdata = 16'haaaa;
        @(posedge clock); #1;
        req = 1'b0; write = 1'b0;
        bus_op(1'b0, 16'h0020, 16'h0, 16'h1111);
        exp_v = sb.pop_front();
        n_cmp++; if (rdata !== exp_v) begin n_fail++; $display("FAIL busy_store got=%h exp=%h", rdata, exp_v); end
    endtask

    task automatic test_reset_pending();
        bus_op(1'b0, 16'h0010, 16'h0, 16'h1234);
        void'(sb.pop_front());
        reset_n = 1'b0;
        #1;
        n_cmp++; if (rvalid !== 1'b0 || ready !== 1'b1 || rdata !== 16'h0) begin
            n_fail++; $display("FAIL rst_pending rvalid=%b ready=%b rdata=%h exp 0/1/0000", rvalid, ready, rdata);
        end
        n_cmp++; if (io_display !== 7'h0 || io_led !== 8'h0) begin
            n_fail++; $display("FAIL rst_io display=%h led=%h exp 00/00", io_display, io_led);
        end
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_no_rvalid got=%b exp=0", rvalid); end
        @(negedge clock);
        reset_n = 1'b1;
        req = 1'b1; write = 1'b0; addr = 16'hfffc; sb.push_back(16'h0000);
        @(posedge clock); #1;
        req = 1'b0;
        exp_v = sb.pop_front();
        n_cmp++; if (rvalid !== 1'b1 || rdata !== exp_v) begin
            n_fail++; $display("FAIL rst_timer rvalid=%b got=%h exp=%h", rvalid, rdata, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_memory();
        test_io_regs();
        test_timer();
        test_debounce();
        test_sticky();
        test_back_to_back();
        test_reset_pending();
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
